// File: rtl/secure_register_file.sv
// Bank of thread-protected registers on the thread-tagged register bus.
// Each entry has an owner thread ID and a sticky lock bit. A denied request gets an
// error and a zero read, and it is logged in a saturating violation counter that also
// records the offending thread ID. Responses are registered with one cycle of latency.
module secure_register_file #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 8,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned TID_WIDTH  = 4,
  parameter int unsigned PRIV_TID   = 0,
  parameter int unsigned VCNT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [1:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [TID_WIDTH-1:0]  req_tid,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic                  clr_viol,
  input  logic [TID_WIDTH-1:0]  clr_tid,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  viol_flag,
  output logic [VCNT_WIDTH-1:0] viol_count,
  output logic [TID_WIDTH-1:0]  viol_tid
);

  typedef enum logic [1:0] {
    OpRead     = 2'b00,
    OpWrite    = 2'b01,
    OpSetOwner = 2'b10,
    OpLock     = 2'b11
  } op_e;

  localparam logic [TID_WIDTH-1:0]  PrivTid = TID_WIDTH'(PRIV_TID);
  localparam logic [VCNT_WIDTH-1:0] VcntMax = '1;

  // Register bank state
  logic [DATA_WIDTH-1:0] data_q  [NUM_REGS];
  logic [TID_WIDTH-1:0]  owner_q [NUM_REGS];
  logic [NUM_REGS-1:0]   lock_q;

  // Response registers
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q;

  // Violation capture registers
  logic                  viol_flag_q, viol_flag_d;
  logic [VCNT_WIDTH-1:0] viol_count_q, viol_count_d;
  logic [TID_WIDTH-1:0]  viol_tid_q, viol_tid_d;

  // Decode / permission signals
  op_e                   op;
  logic [NUM_REGS-1:0]   sel;
  logic                  in_range;
  logic [DATA_WIDTH-1:0] cur_data;
  logic [TID_WIDTH-1:0]  cur_owner;
  logic                  cur_lock;
  logic                  is_priv;
  logic                  is_owner;
  logic                  allowed;
  logic                  granted;
  logic                  denied;
  logic                  clr_ok;
  logic                  clr_bad;

  assign op = op_e'(req_op);

  // Address decode: one-hot entry select plus the selected entry's state.
  // Out-of-range addresses select nothing, which is what flags them as violations.
  always_comb begin
    sel       = '0;
    cur_data  = '0;
    cur_owner = PrivTid;
    cur_lock  = 1'b0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (req_addr == ADDR_WIDTH'(i)) begin
        sel[i]    = 1'b1;
        cur_data  = data_q[i];
        cur_owner = owner_q[i];
        cur_lock  = lock_q[i];
      end
    end
  end

  assign in_range = |sel;
  assign is_priv  = (req_tid == PrivTid);
  assign is_owner = (req_tid == cur_owner);

  // Per-op permission check for the current request.
  always_comb begin
    allowed = 1'b0;
    case (op)
      OpRead:     allowed = is_owner || is_priv;
      OpWrite:    allowed = (is_owner || is_priv) && !cur_lock;
      OpSetOwner: allowed = is_priv && !cur_lock;
      OpLock:     allowed = is_priv;
      default:    allowed = 1'b0;
    endcase
    allowed = allowed && in_range;
  end

  assign granted = req_valid && allowed;
  assign denied  = req_valid && !allowed;
  assign clr_ok  = clr_viol && (clr_tid == PrivTid);
  assign clr_bad = clr_viol && (clr_tid != PrivTid);

  // Commit granted writes, owner changes and locks to the selected entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        data_q[i]  <= '0;
        owner_q[i] <= PrivTid;
      end
      lock_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (granted && sel[i]) begin
          case (op)
            OpWrite:    data_q[i]  <= req_wdata;
            OpSetOwner: owner_q[i] <= req_wdata[TID_WIDTH-1:0];
            OpLock:     lock_q[i]  <= 1'b1;
            default:    ;
          endcase
        end
      end
    end
  end

  // Read data is only exposed for a granted read; everything else returns zero.
  always_comb begin
    rsp_rdata_d = '0;
    if (granted && (op == OpRead)) begin
      rsp_rdata_d = cur_data;
    end
  end

  // Violation next state. An honoured clear wipes the old state first, so a denied
  // request in the same cycle is counted on top of zero. A denied clear and a denied
  // request together add two, and the request's thread ID wins.
  always_comb begin
    logic [VCNT_WIDTH-1:0] base;
    logic [1:0]            inc;
    logic [VCNT_WIDTH+1:0] sum;
    base = clr_ok ? '0 : viol_count_q;
    inc  = {1'b0, denied} + {1'b0, clr_bad};
    sum  = {2'b00, base} + {{VCNT_WIDTH{1'b0}}, inc};
    viol_count_d = (sum > {2'b00, VcntMax}) ? VcntMax : sum[VCNT_WIDTH-1:0];
    viol_flag_d  = (clr_ok ? 1'b0 : viol_flag_q) || denied || clr_bad;
    viol_tid_d   = viol_tid_q;
    if (denied) begin
      viol_tid_d = req_tid;
    end else if (clr_bad) begin
      viol_tid_d = clr_tid;
    end else if (clr_ok) begin
      viol_tid_d = '0;
    end
  end

  // Response and violation registers update on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      viol_flag_q  <= 1'b0;
      viol_count_q <= '0;
      viol_tid_q   <= '0;
    end else begin
      rsp_valid_q  <= req_valid;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= denied;
      viol_flag_q  <= viol_flag_d;
      viol_count_q <= viol_count_d;
      viol_tid_q   <= viol_tid_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;
  assign viol_flag  = viol_flag_q;
  assign viol_count = viol_count_q;
  assign viol_tid   = viol_tid_q;

endmodule

// File: tb/tb_secure_register_file.sv
// Self-checking bench for secure_register_file, built with NUM_REGS = 6 so that
// addresses 6 and 7 exercise the out-of-range path.
module tb_secure_register_file;

  localparam int DW = 32;
  localparam int NR = 6;
  localparam int AW = 3;
  localparam int TW = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic [1:0]    req_op = '0;
  logic [AW-1:0] req_addr = '0;
  logic [TW-1:0] req_tid = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          clr_viol = 1'b0;
  logic [TW-1:0] clr_tid = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          viol_flag;
  logic [CW-1:0] viol_count;
  logic [TW-1:0] viol_tid;

  secure_register_file #(
    .DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW),
    .TID_WIDTH(TW), .PRIV_TID(0), .VCNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr), .req_tid(req_tid),
    .req_wdata(req_wdata), .clr_viol(clr_viol), .clr_tid(clr_tid),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .viol_flag(viol_flag), .viol_count(viol_count), .viol_tid(viol_tid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DW-1:0] m_data  [NR];
  int            m_owner [NR];
  bit            m_lock  [NR];
  int            m_cnt;
  bit            m_flag;
  int            m_tid;

  // Expected response after the most recent step
  bit            e_valid;
  bit            e_err;
  logic [DW-1:0] e_rdata;

  logic [46:0] got;
  logic [46:0] want;

  function automatic void model_reset();
    for (int i = 0; i < NR; i++) begin
      m_data[i] = '0; m_owner[i] = 0; m_lock[i] = 0;
    end
    m_cnt = 0; m_flag = 0; m_tid = 0;
    e_valid = 0; e_err = 0; e_rdata = '0;
  endfunction

  function automatic void log_violation(int tid);
    if (m_cnt < 255) m_cnt++;
    m_flag = 1;
    m_tid  = tid;
  endfunction

  // Apply one cycle of stimulus to both the model and the DUT.
  task automatic step(input bit v, input int op, input int addr, input int tid,
                      input logic [DW-1:0] wd, input bit clr, input int ctid);
    bit ok;
    ok = 0;
    req_valid = v; req_op = 2'(op); req_addr = AW'(addr); req_tid = TW'(tid);
    req_wdata = wd; clr_viol = clr; clr_tid = TW'(ctid);
    e_valid = v; e_err = 0; e_rdata = '0;
    if (clr) begin
      if (ctid == 0) begin m_cnt = 0; m_flag = 0; m_tid = 0; end
      else log_violation(ctid);
    end
    if (v) begin
      if (addr < NR) begin
        case (op)
          0: ok = (tid == m_owner[addr]) || (tid == 0);
          1: ok = ((tid == m_owner[addr]) || (tid == 0)) && !m_lock[addr];
          2: ok = (tid == 0) && !m_lock[addr];
          default: ok = (tid == 0);
        endcase
      end
      if (ok) begin
        case (op)
          0: e_rdata = m_data[addr];
          1: m_data[addr] = wd;
          2: m_owner[addr] = int'(wd[TW-1:0]);
          default: m_lock[addr] = 1;
        endcase
      end else begin
        e_err = 1;
        log_violation(tid);
      end
    end
    @(posedge clk);
    #1;
    req_valid = 0; clr_viol = 0;
    got  = {rsp_valid, rsp_err, rsp_rdata, viol_flag, viol_count, viol_tid};
    want = {e_valid, e_err, e_rdata, m_flag, CW'(m_cnt), TW'(m_tid)};
  endtask

  task automatic test_reset();
    rst_n = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    got = {rsp_valid, rsp_err, rsp_rdata, viol_flag, viol_count, viol_tid};
    checks++;
    if (got !== 47'd0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", got);
    end
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic_rw();
    step(1, 1, 2, 0, 32'hDEADBEEF, 0, 0);
    checks++;
    if (got !== want) begin errors++; $display("FAIL priv_write: got %h want %h", got, want); end
    step(1, 0, 2, 0, '0, 0, 0);
    checks++;
    if (rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0 || rsp_valid !== 1'b1) begin
      errors++; $display("FAIL priv_readback: got rdata %h err %b want deadbeef err 0",
                         rsp_rdata, rsp_err);
    end
  endtask

  task automatic test_denied_read();
    step(1, 0, 2, 3, '0, 0, 0);
    checks++;
    if ({rsp_err, rsp_rdata, viol_flag, viol_count, viol_tid} !== {1'b1, 32'd0, 1'b1, 8'd1, 4'd3})
    begin
      errors++; $display("FAIL denied_read: got %h want %h", got, want);
    end
  endtask

  task automatic test_owner();
    step(1, 2, 5, 0, 32'd3, 0, 0);
    checks++;
    if (got !== want) begin errors++; $display("FAIL set_owner: got %h want %h", got, want); end
    step(1, 1, 5, 3, 32'h1234, 0, 0);
    checks++;
    if (got !== want) begin errors++; $display("FAIL owner_write: got %h want %h", got, want); end
    step(1, 0, 5, 3, '0, 0, 0);
    checks++;
    if (rsp_rdata !== 32'h1234 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL owner_read: got %h/%b want 1234/0", rsp_rdata, rsp_err);
    end
    step(1, 0, 5, 4, '0, 0, 0);
    checks++;
    if (rsp_err !== 1'b1 || viol_tid !== 4'd4) begin
      errors++; $display("FAIL other_thread_read: got err %b tid %0d want 1/4", rsp_err, viol_tid);
    end
  endtask

  task automatic test_lock();
    step(1, 3, 5, 0, '0, 0, 0);
    checks++;
    if (got !== want) begin errors++; $display("FAIL lock: got %h want %h", got, want); end
    step(1, 1, 5, 3, 32'hBAD, 0, 0);
    checks++;
    if (rsp_err !== 1'b1) begin errors++; $display("FAIL locked_write: got err %b want 1", rsp_err); end
    step(1, 2, 5, 0, 32'd7, 0, 0);
    checks++;
    if (rsp_err !== 1'b1) begin errors++; $display("FAIL locked_set_owner: got err %b want 1", rsp_err); end
    step(1, 0, 5, 3, '0, 0, 0);
    checks++;
    if (rsp_rdata !== 32'h1234 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL locked_read: got %h/%b want 1234/0", rsp_rdata, rsp_err);
    end
    step(1, 3, 5, 0, '0, 0, 0);
    checks++;
    if (got !== want) begin errors++; $display("FAIL relock: got %h want %h", got, want); end
  endtask

  task automatic test_range();
    step(1, 0, 7, 0, '0, 0, 0);
    checks++;
    if (got !== want) begin errors++; $display("FAIL range_7: got %h want %h", got, want); end
    step(1, 1, 6, 0, 32'h55, 0, 0);
    checks++;
    if (got !== want) begin errors++; $display("FAIL range_6: got %h want %h", got, want); end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 300; i++) begin
      int op;
      logic [DW-1:0] wd;
      op = int'($urandom_range(0, 3));
      // Locks are sticky; keep them rare so writes and owner changes stay interesting.
      if (op == 3 && $urandom_range(0, 3) != 0) op = 0;
      wd = (op == 2) ? DW'($urandom_range(0, 7)) : DW'($urandom);
      step($urandom_range(0, 7) != 0, op, int'($urandom_range(0, 7)),
           int'($urandom_range(0, 7)), wd, $urandom_range(0, 15) == 0,
           int'($urandom_range(0, 3)));
      checks++;
      if (got !== want) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL random_%0d: got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    step(1, 1, 0, 0, 32'hA5A5_0001, 0, 0);
    step(1, 0, 0, 0, '0, 0, 0);
    checks++;
    if (got !== want) begin errors++; $display("FAIL b2b_read_1: got %h want %h", got, want); end
    step(1, 1, 0, 0, 32'h0BAD_F00D, 0, 0);
    step(1, 0, 0, 0, '0, 0, 0);
    checks++;
    if (rsp_rdata !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL b2b_read_2: got %h want 0badf00d", rsp_rdata);
    end
  endtask

  task automatic test_saturate();
    step(0, 0, 0, 0, '0, 1, 0);
    for (int i = 0; i < 300; i++) step(1, 0, 7, 1, '0, 0, 0);
    checks++;
    if (viol_count !== 8'd255 || got !== want) begin
      errors++; $display("FAIL saturate: got count %0d want 255", viol_count);
    end
  endtask

  task automatic test_clear();
    step(0, 0, 0, 0, '0, 1, 2);
    checks++;
    if (viol_count !== 8'd255 || viol_tid !== 4'd2 || got !== want) begin
      errors++; $display("FAIL bad_clear_saturated: got %h want %h", got, want);
    end
    step(0, 0, 0, 0, '0, 1, 0);
    checks++;
    if ({viol_flag, viol_count, viol_tid} !== 13'd0) begin
      errors++; $display("FAIL good_clear: got %h want 0", {viol_flag, viol_count, viol_tid});
    end
    step(0, 0, 0, 0, '0, 1, 2);
    checks++;
    if (viol_count !== 8'd1 || viol_tid !== 4'd2 || viol_flag !== 1'b1) begin
      errors++; $display("FAIL bad_clear: got cnt %0d tid %0d want 1/2", viol_count, viol_tid);
    end
    step(1, 0, 7, 6, '0, 1, 0);
    checks++;
    if (viol_count !== 8'd1 || viol_tid !== 4'd6 || viol_flag !== 1'b1 || got !== want) begin
      errors++; $display("FAIL clear_plus_deny: got cnt %0d tid %0d want 1/6", viol_count, viol_tid);
    end
    step(1, 0, 7, 5, '0, 1, 9);
    checks++;
    if (viol_count !== 8'd3 || viol_tid !== 4'd5 || got !== want) begin
      errors++; $display("FAIL double_violation: got cnt %0d tid %0d want 3/5", viol_count, viol_tid);
    end
  endtask

  task automatic test_reset_mid();
    step(1, 1, 5, 0, 32'hFFFF_FFFF, 0, 0);
    step(1, 0, 3, 9, '0, 0, 0);
    req_valid = 1; req_op = 2'd0; req_addr = 3'd3; req_tid = 4'd0;
    #2;
    rst_n = 0;
    #1;
    model_reset();
    got = {rsp_valid, rsp_err, rsp_rdata, viol_flag, viol_count, viol_tid};
    checks++;
    if (got !== 47'd0) begin errors++; $display("FAIL mid_reset_outputs: got %h want 0", got); end
    @(negedge clk);
    req_valid = 0;
    rst_n = 1;
    @(posedge clk);
    #1;
    step(1, 0, 5, 0, '0, 0, 0);
    checks++;
    if (got !== want) begin errors++; $display("FAIL post_reset_data: got %h want %h", got, want); end
    step(1, 2, 5, 0, 32'd4, 0, 0);
    checks++;
    if (rsp_err !== 1'b0) begin errors++; $display("FAIL post_reset_unlocked: got err %b want 0", rsp_err); end
  endtask

  initial begin
    test_reset();
    test_basic_rw();
    test_denied_read();
    test_owner();
    test_lock();
    test_range();
    test_back_to_back();
    test_random();
    test_saturate();
    test_clear();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete, want completion");
    $fatal(1);
  end

endmodule

// File: doc/secure_register_file.md
Name: secure_register_file

Overview:
- Parametrised successor to the single secure register: a bank of NUM_REGS thread-protected registers.
- Each register has a per-entry owner thread ID and a sticky lock bit.
- Denied accesses return an error and a zeroed read. They are also logged in a saturating violation counter, with the offending thread ID captured.
- Sits on the thread-tagged register bus between the multithreaded core and protected configuration state.

Parameters:
- DATA_WIDTH, 32, width of each register and the data buses
- NUM_REGS, 8, number of registers (power of two not required, ≥1)
- ADDR_WIDTH, 3, request address width; must satisfy 2**ADDR_WIDTH ≥ NUM_REGS
- TID_WIDTH, 4, thread ID width
- PRIV_TID, 0, privileged thread ID
- VCNT_WIDTH, 8, violation counter width

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present this cycle
- req_op  input  2  00 read, 01 write, 10 set_owner, 11 lock
- req_addr  input  ADDR_WIDTH  register index
- req_tid  input  TID_WIDTH  requesting thread ID
- req_wdata  input  DATA_WIDTH  write data; set_owner uses bits [TID_WIDTH-1:0]
- clr_viol  input  1  request to clear violation state
- clr_tid  input  TID_WIDTH  thread issuing clr_viol
- rsp_valid  output  1  response for the previous cycle's request
- rsp_rdata  output  DATA_WIDTH  read data, 0 unless a permitted read
- rsp_err  output  1  request denied or out of range
- viol_flag  output  1  sticky; at least one violation since the last clear
- viol_count  output  VCNT_WIDTH  saturating count of violations
- viol_tid  output  TID_WIDTH  req_tid of the most recent violation

Behaviour:
- Reset (async assert, sync release):
  - All data = 0; owner[i] = PRIV_TID; lock[i] = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - viol_flag = 0, viol_count = 0, viol_tid = 0.
- Reset mid-operation: the in-flight response is dropped (rsp_valid = 0); no state is retained.
- Request acceptance and response timing:
  - A request is accepted every cycle where req_valid = 1; there is no backpressure.
  - The response is registered with 1-cycle latency: rsp_valid(t+1) = req_valid(t).
- Range check: if req_addr ≥ NUM_REGS, the request is a violation and state is unchanged.
- Permission per op, for in-range addr a:
  - read: allowed if req_tid == owner[a] or req_tid == PRIV_TID. On success rsp_rdata = data[a].
  - write: allowed if (req_tid == owner[a] or req_tid == PRIV_TID) and lock[a] == 0. On success data[a] <= req_wdata.
  - set_owner: allowed only if req_tid == PRIV_TID and lock[a] == 0. On success owner[a] <= req_wdata[TID_WIDTH-1:0].
  - lock: allowed only if req_tid == PRIV_TID. Sets lock[a] = 1. The lock is sticky until reset; re-locking an already locked register is allowed and not an error.
- Denied request:
  - rsp_err = 1 and rsp_rdata = 0; no state change.
  - viol_flag <= 1; viol_count increments, saturating at 2**VCNT_WIDTH-1; viol_tid <= req_tid.
- Permitted request: rsp_err = 0. rsp_rdata = 0 for every op except read.
- Write-then-read to the same address on consecutive cycles: the read returns the new value (the write commits at the end of cycle t).
- clr_viol:
  - Honoured only if clr_tid == PRIV_TID: viol_flag, viol_count and viol_tid are zeroed.
  - If clr_tid != PRIV_TID, clr_viol is itself a violation: count +1, viol_tid <= clr_tid.
- Simultaneous events in one cycle:
  - Honoured clear plus a denied request: the clear applies first, giving count = 1, flag = 1, viol_tid = req_tid.
  - Denied clear plus a denied request: count +2 (saturating), viol_tid <= req_tid.
- Violation capture is independent of rsp path timing and updates on the same edge as the response registers.

Test Plan:
- Reset, then PRIV_TID(0) writes 0xDEADBEEF to reg 2 and reads it back -> rsp_rdata = 0xDEADBEEF, rsp_err = 0, one cycle after each request.
- Thread 3 reads reg 2 (owner 0) -> rsp_err = 1, rsp_rdata = 0, viol_count = 1, viol_tid = 3, viol_flag = 1.
- PRIV sets owner[5] = 3; thread 3 writes 0x1234 to reg 5 and reads it -> 0x1234, no error. Thread 4 reads reg 5 -> error.
- PRIV locks reg 5. Thread 3 write -> error and data stays 0x1234. PRIV set_owner on reg 5 -> error. Thread 3 read -> 0x1234, no error.
- Out-of-range addr (e.g. 7 when NUM_REGS = 6) -> error. Then 300 denied reads with VCNT_WIDTH = 8 -> viol_count saturates at 255.
- clr_viol with clr_tid = 2 -> count +1, viol_tid = 2. clr_viol with clr_tid = 0 in the same cycle as a thread-6 denied read -> count = 1, viol_tid = 6. Assert rst_n mid-stream -> all outputs 0 immediately.
